// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   ctrlStateT - controller FSM encoding (StRun / StPend)
//   NopInstr   - canonical RV32I NOP (addi x0,x0,0) loaded by flush consumers
//   DefaultXlen - default PC / redirect target width
package pipe_stall_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StPend = 1'b1
  } ctrlStateT;

  localparam int unsigned DefaultXlen = 32;
  localparam logic [31:0] NopInstr    = 32'h0000_0013;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the stall controller and the pipeline/hazard/cache logic.
//   master : controller side - receives requests, drives stage enables, PC control, counters
//   slave  : pipeline side   - drives requests, consumes the control outputs
interface pipe_stall_ctrl_if import pipe_stall_ctrl_pkg::*; #(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned CNT_W = 32
);

  logic             load_use_i;
  logic             icache_stall_i;
  logic             dcache_stall_i;
  logic             branch_flush_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             perf_clr_i;
  logic             pc_write_o;
  logic             pc_sel_redirect_o;
  logic [XLEN-1:0]  pc_redirect_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_write_o;
  logic             id_ex_bubble_o;
  logic             ex_mem_write_o;
  logic             mem_wb_write_o;
  logic             redirect_pend_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    input  load_use_i, icache_stall_i, dcache_stall_i, branch_flush_i, redirect_pc_i,
           perf_clr_i,
    output pc_write_o, pc_sel_redirect_o, pc_redirect_o, if_id_write_o, if_id_flush_o,
           id_ex_write_o, id_ex_bubble_o, ex_mem_write_o, mem_wb_write_o, redirect_pend_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    output load_use_i, icache_stall_i, dcache_stall_i, branch_flush_i, redirect_pc_i,
           perf_clr_i,
    input  pc_write_o, pc_sel_redirect_o, pc_redirect_o, if_id_write_o, if_id_flush_o,
           id_ex_write_o, id_ex_bubble_o, ex_mem_write_o, mem_wb_write_o, redirect_pend_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n - clock, async active-low reset (count -> 0)
//   inc_i      - increment by one this cycle (held at all-ones once reached)
//   clr_i      - synchronous clear, wins over inc_i
//   count_o    - current count
module pipe_stall_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cntQ, cntD;

  always_comb begin
    cntD = cntQ;
    if (clr_i) begin
      cntD = '0;
    end else if (inc_i && (cntQ != '1)) begin
      cntD = cntQ + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign count_o = cntQ;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller for the 5-stage core. Arbitrates D-cache freeze, branch
// redirect (immediate or deferred), load-use stall and I-cache stall, and drives the
// per-stage register enables, flush/bubble controls and the PC mux.
//   clk, rst_n - core clock, async active-low reset
//   bus        - pipe_stall_ctrl_if.master: requests in, stage/PC controls and
//                saturating stall/flush performance counters out
// All controls are combinational from the FSM state and the current requests.
module pipe_stall_ctrl import pipe_stall_ctrl_pkg::*; #(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stall_ctrl_if.master bus
);

  ctrlStateT       stateQ, stateD;
  logic [XLEN-1:0] pendPcQ, pendPcD;

  logic            pcWrite, pcSel, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
  logic            exMemWrite, memWbWrite, flushInc;
  logic [XLEN-1:0] pcRedirect;
  logic            redirectReq;

  // A redirect is owed either by a fresh mispredict or by one deferred earlier.
  assign redirectReq = bus.branch_flush_i || (stateQ == StPend);

  always_comb begin
    stateD     = stateQ;
    pendPcD    = pendPcQ;
    pcWrite    = 1'b1;
    pcSel      = 1'b0;
    pcRedirect = pendPcQ;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExWrite  = 1'b1;
    idExBubble = 1'b0;
    exMemWrite = 1'b1;
    memWbWrite = 1'b1;
    flushInc   = 1'b0;

    if (bus.dcache_stall_i) begin
      // Whole pipe frozen; a mispredict arriving now is remembered for later.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      memWbWrite = 1'b0;
      if (bus.branch_flush_i) begin
        pendPcD = bus.redirect_pc_i;
        stateD  = StPend;
      end
    end else if (redirectReq && bus.icache_stall_i) begin
      // Kill wrong-path work now, but the fetch unit cannot take the new PC yet.
      pcWrite    = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = bus.branch_flush_i;
      if (bus.branch_flush_i) begin
        pendPcD = bus.redirect_pc_i;
        stateD  = StPend;
      end
    end else if (redirectReq) begin
      pcSel      = 1'b1;
      pcRedirect = bus.branch_flush_i ? bus.redirect_pc_i : pendPcQ;
      ifIdFlush  = 1'b1;
      idExBubble = bus.branch_flush_i;
      stateD     = StRun;
      flushInc   = 1'b1;
    end else if (bus.load_use_i) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end else if (bus.icache_stall_i) begin
      pcWrite   = 1'b0;
      ifIdFlush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= StRun;
      pendPcQ <= '0;
    end else begin
      stateQ  <= stateD;
      pendPcQ <= pendPcD;
    end
  end

  pipe_stall_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (~pcWrite),
    .clr_i   (bus.perf_clr_i),
    .count_o (bus.stall_cnt_o)
  );

  pipe_stall_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (flushInc),
    .clr_i   (bus.perf_clr_i),
    .count_o (bus.flush_cnt_o)
  );

  assign bus.pc_write_o        = pcWrite;
  assign bus.pc_sel_redirect_o = pcSel;
  assign bus.pc_redirect_o     = pcRedirect;
  assign bus.if_id_write_o     = ifIdWrite;
  assign bus.if_id_flush_o     = ifIdFlush;
  assign bus.id_ex_write_o     = idExWrite;
  assign bus.id_ex_bubble_o    = idExBubble;
  assign bus.ex_mem_write_o    = exMemWrite;
  assign bus.mem_wb_write_o    = memWbWrite;
  assign bus.redirect_pend_o   = (stateQ == StPend);

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline-control block that consumes hazard and stall requests and drives per-stage write enables, bubbles/flushes and PC redirect for the 5-stage RISC-V core. Inputs are the load-use stall request from the hazard detector, I/D-cache stall requests and EX-stage branch-mispredict flushes. Outputs drive the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC mux. It holds a pending redirect when a mispredict cannot be serviced immediately, and keeps saturating performance counters.

Parameters:
XLEN, 32, width of PC / redirect target
CNT_W, 32, width of each performance counter (saturating)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_use_i  in  1  load-use stall request from hazard detector
icache_stall_i  in  1  I-cache miss in progress
dcache_stall_i  in  1  D-cache miss in progress; freezes whole pipe
branch_flush_i  in  1  EX mispredict; redirect required
redirect_pc_i  in  XLEN  correct target from EX, valid with branch_flush_i
perf_clr_i  in  1  synchronous clear of both counters
pc_write_o  out  1  PC register enable
pc_sel_redirect_o  out  1  PC mux selects pc_redirect_o
pc_redirect_o  out  XLEN  redirect target
if_id_write_o  out  1  IF/ID enable
if_id_flush_o  out  1  load NOP into IF/ID
id_ex_write_o  out  1  ID/EX enable
id_ex_bubble_o  out  1  load NOP control into ID/EX
ex_mem_write_o  out  1  EX/MEM enable
mem_wb_write_o  out  1  MEM/WB enable
redirect_pend_o  out  1  pending redirect held
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
flush_cnt_o  out  CNT_W  redirects issued

Behaviour:
- Reset: one clock (clk), reset asynchronous active-low (rst_n); reset clears FSM to RUN, pend target to 0, both counters to 0. All outputs are combinational from state+inputs. With all request inputs low after reset: every *_write_o=1, all flush/bubble/sel=0.
- FSM: RUN, PEND. PEND holds latched target pend_pc.
- Priority each cycle (first match wins):
  1. dcache_stall_i: all *_write_o=0, pc_write_o=0, no flush/bubble/sel. If branch_flush_i: latch redirect_pc_i into pend_pc, go PEND.
  2. branch_flush_i or state==PEND, icache_stall_i=1: pc_write_o=0; if_id_flush_o=1; id_ex_bubble_o=branch_flush_i; others write=1. If branch_flush_i: latch redirect_pc_i, go PEND (overwrites old pend_pc).
  3. branch_flush_i or PEND, icache_stall_i=0: pc_write_o=1, pc_sel_redirect_o=1, pc_redirect_o = branch_flush_i ? redirect_pc_i : pend_pc; if_id_flush_o=1; id_ex_bubble_o=branch_flush_i; next state RUN; flush_cnt +1.
  4. load_use_i: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, others write=1.
  5. icache_stall_i: pc_write_o=0, if_id_flush_o=1, others write=1.
  6. else normal flow.
- Branch flush overrides load-use (load-use instruction is on the wrong path).
- pc_redirect_o = pend_pc whenever no redirect is issued (stable, no X).
- redirect_pend_o = (state==PEND).
- Counters: stall_cnt +1 each cycle pc_write_o=0; flush_cnt +1 per redirect issue (case 3). Both saturate at all-ones. perf_clr_i has priority over increment; value 0 next cycle.
- Reset asserted mid-PEND: pend discarded, RUN immediately (async).

Decomposition:
- Shared package: FSM state encoding (RUN=1'b0, PEND=1'b1), NOP instruction constant used by flush consumers, default XLEN.
- One sub-module natural: sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Reset, idle inputs -> all writes 1, flush/bubble/sel 0, counters 0, redirect_pend_o 0.
- load_use_i=1 one cycle -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; stall_cnt=1 after.
- branch_flush_i=1, redirect_pc_i=0x0000_0100, no stalls -> pc_sel_redirect_o=1, pc_redirect_o=0x100, if_id_flush_o=1, id_ex_bubble_o=1, flush_cnt=1.
- branch_flush_i with target 0x200 while icache_stall_i=1 for 3 cycles -> PEND, pc_write_o=0 for 3 cycles; on stall release pc_redirect_o=0x200, sel=1 one cycle, then RUN.
- dcache_stall_i=1 with load_use_i=1 and branch_flush_i=1 (target 0x300) -> all writes 0; on release redirect to 0x300 issued, load_use ignored that cycle.
- Force stall_cnt to all-ones-1, stall 3 cycles -> saturates at all-ones; perf_clr_i=1 -> 0; rst_n low during PEND -> redirect_pend_o=0 immediately.
